btn_debounce_multi: RTL

//  N-channel push-button conditioner: synchronises, debounces and classifies button activity.
//  Per channel: stable level, one-cycle press/release pulses, long-press pulse, optional auto-repeat.

---
 rtl/btn_debounce_multi.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: N-channel push-button conditioner.
// Each channel is synchronised and debounced. It reports a stable level,
// one-cycle press/release strobes, a long-press strobe and an optional
// auto-repeat strobe. All strobes and levels are registered outputs.
module btn_debounce_multi #(
    parameter int N_BTN             = 2,
    parameter int DEBOUNCE_CYCLES   = 6750000,
    parameter int LONG_PRESS_CYCLES = 0,
    parameter int REPEAT_CYCLES     = 0,
    parameter int ACTIVE_LOW        = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_press_pulse,
    output logic [N_BTN-1:0] repeat_pulse,
    output logic             any_press
);

    localparam int DW   = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HMAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
    localparam int HW   = (HMAX < 1) ? 1 : $clog2(HMAX + 1);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST = (LONG_PRESS_CYCLES > 0) ? HW'(LONG_PRESS_CYCLES - 1) : {HW{1'b0}};
    localparam logic [HW-1:0] REP_LAST  = (REPEAT_CYCLES > 0) ? HW'(REPEAT_CYCLES - 1) : {HW{1'b0}};
    localparam logic [HW-1:0] HOLD_SAT  = {HW{1'b1}};
    localparam bit            LONG_EN   = (LONG_PRESS_CYCLES != 0);
    localparam bit            REP_EN    = LONG_EN && (REPEAT_CYCLES != 0);

    // Reject parameter sets that would make strobes degenerate.
    generate
        if (N_BTN < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES == 1 ||
            LONG_PRESS_CYCLES < 0 || REPEAT_CYCLES < 0) begin : g_bad_params
            $error("btn_debounce_multi: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } hold_state_t;

    // Polarity is applied ahead of the synchroniser so all later logic sees 1 = pressed.
    logic [N_BTN-1:0] pol_s;
    logic [N_BTN-1:0] press_nxt_s;

    assign pol_s = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic        s1_r, s2_r;
        logic        level_r, press_r, release_r, long_r, rep_r;
        logic        level_s, press_s, release_s, long_s, rep_s;
        logic [DW-1:0] db_r, db_s;
        logic [HW-1:0] hold_r, hold_s;
        hold_state_t   st_r, st_s;

        // Next-state for debounce counter, hold timer and hold FSM of this channel.
        always_comb begin
            db_s      = db_r;
            level_s   = level_r;
            press_s   = 1'b0;
            release_s = 1'b0;
            long_s    = 1'b0;
            rep_s     = 1'b0;
            hold_s    = hold_r;
            st_s      = st_r;

            // Any disagreement that does not last DEBOUNCE_CYCLES restarts from zero.
            if (s2_r == level_r) begin
                db_s = {DW{1'b0}};
            end else if (db_r == DB_LAST) begin
                db_s      = {DW{1'b0}};
                level_s   = s2_r;
                press_s   = s2_r;
                release_s = ~s2_r;
            end else begin
                db_s = db_r + DW'(1);
            end

            // Hold timer is zero in the press cycle and counts while the level stays high.
            if (!level_r) begin
                hold_s = {HW{1'b0}};
            end else if (hold_r != HOLD_SAT) begin
                hold_s = hold_r + HW'(1);
            end else begin
                hold_s = hold_r;
            end

            case (st_r)
                ST_IDLE: begin
                    if (press_s && LONG_EN) begin
                        st_s = ST_HELD;
                    end else begin
                        st_s = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    // A release in the same cycle wins over the long-press strobe.
                    if (release_s) begin
                        st_s = ST_IDLE;
                    end else if (hold_r == LONG_LAST) begin
                        long_s = 1'b1;
                        hold_s = {HW{1'b0}};
                        st_s   = ST_LONG;
                    end else begin
                        st_s = ST_HELD;
                    end
                end
                ST_LONG: begin
                    if (release_s) begin
                        st_s = ST_IDLE;
                    end else if (REP_EN && hold_r == REP_LAST) begin
                        rep_s  = 1'b1;
                        hold_s = {HW{1'b0}};
                        st_s   = ST_LONG;
                    end else begin
                        st_s = ST_LONG;
                    end
                end
                default: begin
                    st_s = ST_IDLE;
                end
            endcase
        end

        // Channel state registers; reset discards any debounce or hold progress.
        always_ff @(posedge clk) begin
            if (reset) begin
                s1_r      <= 1'b0;
                s2_r      <= 1'b0;
                db_r      <= {DW{1'b0}};
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;
                rep_r     <= 1'b0;
                hold_r    <= {HW{1'b0}};
                st_r      <= ST_IDLE;
            end else begin
                s1_r      <= pol_s[i];
                s2_r      <= s1_r;
                db_r      <= db_s;
                level_r   <= level_s;
                press_r   <= press_s;
                release_r <= release_s;
                long_r    <= long_s;
                rep_r     <= rep_s;
                hold_r    <= hold_s;
                st_r      <= st_s;
            end
        end

        assign btn_level[i]        = level_r;
        assign press_pulse[i]      = press_r;
        assign release_pulse[i]    = release_r;
        assign long_press_pulse[i] = long_r;
        assign repeat_pulse[i]     = rep_r;
        assign press_nxt_s[i]      = press_s;
    end

    // any_press is registered from the same next-values so it aligns with press_pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_nxt_s;
        end
    end

endmodule
